// File: rtl/cache_exerciser_pkg.sv
// Shared types and constants for the cache exerciser.
package cache_exerciser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_GAP,
      RD_ISSUE,
      RD_WAIT,
      DONE
   } state_e;

   localparam logic [1:0] MODE_CONST = 2'd0;
   localparam logic [1:0] MODE_ADDR  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_WALK  = 2'd3;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   // One right-shifting Galois LFSR step.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/cache_exerciser_pattern_gen.sv
// Test-pattern generator. All inputs describe the NEXT word (next-state
// values from the controller), so the output can be registered directly.
module pattern_gen
   import cache_exerciser_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [IDX_W-1:0]      index,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  step,
   input  logic                  restart,
   output logic [DATA_WIDTH-1:0] pattern
);

   logic [31:0]             lfsr_q, lfsr_d, seed32, seed_nz;
   logic [2*DATA_WIDTH-1:0] rot_dbl;
   logic [31:0]             rot_amt;

   // LFSR next value: reload from (non-zero) seed, step once per word, or hold.
   always_comb begin
      seed32  = 32'(seed);
      seed_nz = (seed32 == 32'd0) ? 32'd1 : seed32;
      lfsr_d  = lfsr_q;
      if (restart)   lfsr_d = seed_nz;
      else if (step) lfsr_d = lfsr_step(lfsr_q);
   end

   // LFSR state tracks the current word index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 32'd1;
      else     lfsr_q <= lfsr_d;
   end

   // Pattern select; walking mode rotates seed left by index mod width.
   always_comb begin
      rot_amt = 32'(index) % 32'(DATA_WIDTH);
      rot_dbl = {seed, seed} << rot_amt;
      case (mode)
         MODE_CONST: pattern = seed;
         MODE_ADDR:  pattern = DATA_WIDTH'(address);
         MODE_LFSR:  pattern = DATA_WIDTH'(lfsr_d);
         default:    pattern = rot_dbl[2*DATA_WIDTH-1:DATA_WIDTH];
      endcase
   end

endmodule

// File: rtl/cache_exerciser.sv
// Cache exerciser: writes a pattern over an address range, reads it back,
// and counts mismatches and read timeouts.
module cache_exerciser
   import cache_exerciser_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    WORD_COUNT = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    STRIDE     = 4,
   parameter int                    TIMEOUT    = 255
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic                  data_out_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           error_count,
   output logic [ADDR_WIDTH-1:0] first_fail_addr,
   output logic [5:0]            led
);

   localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORD_COUNT - 1);
   localparam logic [TMO_W-1:0]      LAST_WAIT = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP_ADDR = ADDR_WIDTH'(STRIDE);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d, ffa_q, ffa_d;
   logic [DATA_WIDTH-1:0]   din_q, exp_q, seed_q, seed_d, pattern;
   logic                    we_q, we_d, pg_step, pg_restart;
   logic [1:0]              mode_q, mode_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [TMO_W-1:0]        wait_q, wait_d;
   logic [15:0]             err_q, err_d;

   pattern_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_pattern_gen (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .mode    (mode_d),
      .seed    (seed_d),
      .index   (idx_d),
      .address (addr_d),
      .step    (pg_step),
      .restart (pg_restart),
      .pattern (pattern)
   );

   // Next-state logic: write phase, then read-back/compare phase.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mode_d     = mode_q;
      seed_d     = seed_q;
      idx_d      = idx_q;
      wait_d     = wait_q;
      err_d      = err_q;
      ffa_d      = ffa_q;
      pg_step    = 1'b0;
      pg_restart = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mode_d     = mode;
               seed_d     = seed;
               addr_d     = BASE_ADDR;
               idx_d      = '0;
               err_d      = '0;
               ffa_d      = '0;
               pg_restart = 1'b1;
               state_d    = WR;
            end
         end
         WR: state_d = WR_GAP;
         WR_GAP: begin
            if (idx_q == LAST_IDX) begin
               addr_d     = BASE_ADDR;
               idx_d      = '0;
               pg_restart = 1'b1;
               state_d    = RD_ISSUE;
            end else begin
               addr_d  = addr_q + STEP_ADDR;
               idx_d   = idx_q + 1'b1;
               pg_step = 1'b1;
               state_d = WR;
            end
         end
         RD_ISSUE: begin
            wait_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (data_out_valid || wait_q == LAST_WAIT) begin
               if (!data_out_valid || data_out != exp_q) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (err_q == 16'd0)    ffa_d = addr_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + STEP_ADDR;
                  idx_d   = idx_q + 1'b1;
                  pg_step = 1'b1;
                  state_d = RD_ISSUE;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      we_d = (state_d == WR);
   end

   // State and datapath registers; write data and expected data are taken
   // from the generator, which already reflects the next word.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         addr_q  <= BASE_ADDR;
         din_q   <= '0;
         exp_q   <= '0;
         we_q    <= 1'b0;
         mode_q  <= '0;
         seed_q  <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         err_q   <= '0;
         ffa_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         if (we_d) din_q <= pattern;
         exp_q   <= pattern;
         we_q    <= we_d;
         mode_q  <= mode_d;
         seed_q  <= seed_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         ffa_q   <= ffa_d;
      end
   end

   assign address         = addr_q;
   assign data_in         = din_q;
   assign write_enable    = we_q;
   assign busy            = (state_q != IDLE) && (state_q != DONE);
   assign done            = (state_q == DONE);
   assign pass            = done && (err_q == 16'd0);
   assign error_count     = err_q;
   assign first_fail_addr = ffa_q;
   assign led             = {done, pass, err_q[3:0]};

endmodule

// File: doc/cache_exerciser.md
CACHE_EXERCISER -- requirements
Module: cache_exerciser

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the cache address bus.
REQ-002 Parameter DATA_WIDTH, default 32: width of the cache data buses.
REQ-003 Parameter WORD_COUNT, default 1024: words per pass, at least 1.
REQ-004 Parameter BASE_ADDR, default 0: first address of the pass.
REQ-005 Parameter STRIDE, default 4: address increment per word.
REQ-006 Parameter TIMEOUT, default 255: maximum read-wait cycles, at least 2.
REQ-007 Port sys_clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-008 Port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port start, input, 1 bit: a one-cycle pulse that launches a pass.
REQ-010 Port mode, input, 2 bits: pattern select, sampled when start is accepted.
REQ-011 Port seed, input, DATA_WIDTH: pattern seed, sampled when start is accepted.
REQ-012 Port address, output, ADDR_WIDTH: cache address, registered.
REQ-013 Port data_in, output, DATA_WIDTH: cache write data, registered.
REQ-014 Port write_enable, output, 1 bit: cache write strobe, registered.
REQ-015 Port data_out, input, DATA_WIDTH: cache read data.
REQ-016 Port data_out_valid, input, 1 bit: cache hit/ready indication for the current address.
REQ-017 Port busy, output, 1 bit: high while a pass is running.
REQ-018 Port done, output, 1 bit: high from pass end until the next accepted start.
REQ-019 Port pass, output, 1 bit: high with done when error_count equals 0.
REQ-020 Port error_count, output, 16 bits: mismatches plus timeouts; saturates at 0xFFFF.
REQ-021 Port first_fail_addr, output, ADDR_WIDTH: address of the first failure; 0 if there is none.
REQ-022 Port led, output, 6 bits: {done, pass, error_count[3:0]}.

Function
REQ-023 States: IDLE, WR, WR_GAP, RD_ISSUE, RD_WAIT, DONE.
REQ-024 IDLE or DONE plus start: clear error_count and first_fail_addr, latch mode and seed, set address to BASE_ADDR, then go to WR.
REQ-025 Start while busy shall be ignored.
REQ-026 WR: drive data_in with pattern(i) and write_enable=1 for exactly one cycle, then go to WR_GAP.
REQ-027 WR_GAP: write_enable=0 for one cycle; advance address by STRIDE and i by 1.
REQ-028 After word WORD_COUNT-1, WR_GAP goes to RD_ISSUE, with address reset to BASE_ADDR and i reset to 0.
REQ-029 RD_ISSUE: hold address for one cycle with write_enable=0, then go to RD_WAIT; data_out_valid is never sampled in RD_ISSUE.
REQ-030 RD_WAIT: on data_out_valid=1, compare data_out with pattern(i); a mismatch is one error.
REQ-031 RD_WAIT: if data_out_valid stays 0 for TIMEOUT cycles, record one error and move on.
REQ-032 After each compare or timeout, advance address and i; after word WORD_COUNT-1, go to DONE.
REQ-033 On the first error of a pass, latch first_fail_addr from the current address.
REQ-034 Patterns: mode 0 = seed; mode 1 = address zero-extended or truncated to DATA_WIDTH; mode 2 = 32-bit Galois LFSR (taps 0x80200003, seed 0 replaced by 1), stepped once per word, restarted from seed for the read phase; mode 3 = seed rotated left by (i mod DATA_WIDTH).
REQ-035 Address arithmetic is modulo 2^ADDR_WIDTH; wrap is permitted and not flagged.
REQ-036 When WORD_COUNT is 1, each phase issues one word.
REQ-037 busy=1 in every state except IDLE and DONE.

Reset
REQ-038 On sys_rst high, without waiting for a clock edge: state=IDLE, address=BASE_ADDR, data_in=0, write_enable=0, busy=0, done=0, pass=0, error_count=0, first_fail_addr=0, led=0.
REQ-039 Reset asserted mid-pass shall abort the pass; no write_enable pulse shall follow release until the next start.

Structure
REQ-040 Package cache_exerciser_pkg holds the state enum, the mode constants (MODE_CONST, MODE_ADDR, MODE_LFSR, MODE_WALK) and the LFSR tap constant.
REQ-041 One sub-module, pattern_gen (mode, seed, index, address, step, restart -> pattern), computes the expected and written data.

Verification
REQ-042 Ideal cache model (valid one cycle after address change), mode 1, WORD_COUNT=8 -> 8 single-cycle writes at 0x00..0x1C, then 8 reads, done=1, pass=1, error_count=0.
REQ-043 Mode 2, seed 0 -> identical to seed 1; pass=1; the data_in sequence matches the reference LFSR.
REQ-044 Model corrupts the word at 0x0C -> error_count=1, first_fail_addr=0x0C, led=6'b100001.
REQ-045 Model never asserts valid, TIMEOUT=4, WORD_COUNT=3 -> error_count=3 and done after 3 timeouts.
REQ-046 Start pulsed during WR -> ignored; reset asserted during RD_WAIT -> all outputs reach reset values immediately, and no write follows release.
REQ-047 BASE_ADDR=0xFFFFFFF8, WORD_COUNT=4 -> addresses FFFFFFF8, FFFFFFFC, 0, 4 and pass=1.
